// File: rtl/fountain_pkg.sv
// Shared types and helpers for the parametrised LT fountain encoder.
package fountain_pkg;

  localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ENCODE = 2'd2,
    EMIT   = 2'd3
  } state_e;

  // One right-shift Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 32'd0);
  endfunction

endpackage

// File: rtl/fountain_symbol_buf.sv
// K x W source symbol register file: one synchronous write port, one asynchronous read port.
module fountain_symbol_buf #(
  parameter int unsigned W  = 64,
  parameter int unsigned K  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [K];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fountain_lt_encoder.sv
// LT fountain encoder: buffers K source symbols, emits NUM_OUT XOR-coded symbols with LFSR tags.
// Optional build macro FOUNTAIN_SYSTEMATIC_EN: first K outputs are the raw source symbols.
module fountain_lt_encoder
  import fountain_pkg::*;
#(
  parameter int unsigned W       = 64,
  parameter int unsigned K       = 32,
  parameter int unsigned NUM_OUT = 48,
  parameter logic [31:0] POLY    = DEFAULT_POLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  seed,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [31:0]  out_tag,
  output logic [15:0]  out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned AW       = (K > 1) ? $clog2(K) : 1;
  localparam logic [AW-1:0] LAST_J = AW'(K - 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_OUT - 1);

  state_e        r_state, w_state_n;
  logic [31:0]   r_lfsr, w_lfsr_n, r_tag, w_tag_n, r_out_tag, w_out_tag_n;
  logic [AW-1:0] r_j, w_j_n, r_wr, w_wr_n, r_fidx, w_fidx_n, w_raddr;
  logic [W-1:0]  r_acc, w_acc_n, r_out_data, w_out_data_n, w_rdata;
  logic [15:0]   r_out_idx, w_out_idx_n;
  logic          r_out_valid, w_out_valid_n, r_done, w_done_n, r_in_ready, r_busy;
  logic          w_we, w_inc, w_sys_cur, w_sys_nxt;

`ifdef FOUNTAIN_SYSTEMATIC_EN
  assign w_sys_cur = (32'(r_out_idx) < K);
  assign w_sys_nxt = ((32'(r_out_idx) + 32'd1) < K);
`else
  assign w_sys_cur = 1'b0;
  assign w_sys_nxt = 1'b0;
`endif

  fountain_symbol_buf #(.W(W), .K(K), .AW(AW)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr),
    .i_wdata (in_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Source symbol j joins the XOR when the LFSR LSB is set or j is the forced index.
  assign w_inc = r_lfsr[0] | (r_j == r_fidx);

  always_comb begin
    w_state_n     = r_state;
    w_lfsr_n      = r_lfsr;
    w_tag_n       = r_tag;
    w_j_n         = r_j;
    w_wr_n        = r_wr;
    w_fidx_n      = r_fidx;
    w_acc_n       = r_acc;
    w_out_data_n  = r_out_data;
    w_out_tag_n   = r_out_tag;
    w_out_idx_n   = r_out_idx;
    w_out_valid_n = r_out_valid;
    w_done_n      = 1'b0;
    w_we          = 1'b0;
    w_raddr       = r_j;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n   = LOAD;
          w_lfsr_n    = (seed == 32'd0) ? 32'd1 : seed;
          w_wr_n      = '0;
          w_j_n       = '0;
          w_fidx_n    = '0;
          w_out_idx_n = '0;
        end
      end
      LOAD: begin
        if (in_valid && r_in_ready) begin
          w_we = 1'b1;
          if (r_wr == LAST_J) begin
            w_wr_n    = '0;
            w_state_n = w_sys_cur ? EMIT : ENCODE;
          end else begin
            w_wr_n = r_wr + AW'(1);
          end
        end
      end
      ENCODE: begin
        w_acc_n  = ((r_j == '0) ? '0 : r_acc) ^ (w_inc ? w_rdata : '0);
        if (r_j == '0) w_tag_n = r_lfsr;
        w_lfsr_n = lfsr_step(r_lfsr, POLY);
        if (r_j == LAST_J) begin
          w_j_n     = '0;
          w_state_n = EMIT;
        end else begin
          w_j_n = r_j + AW'(1);
        end
      end
      EMIT: begin
        w_raddr = r_out_idx[AW-1:0];
        if (!r_out_valid) begin
          w_out_valid_n = 1'b1;
          w_out_data_n  = w_sys_cur ? w_rdata : r_acc;
          w_out_tag_n   = w_sys_cur ? 32'd0 : r_tag;
        end else if (out_ready) begin
          w_out_valid_n = 1'b0;
          w_fidx_n      = (r_fidx == LAST_J) ? '0 : r_fidx + AW'(1);
          if (r_out_idx == LAST_IDX) begin
            w_done_n    = 1'b1;
            w_state_n   = IDLE;
            w_out_idx_n = '0;
            w_fidx_n    = '0;
          end else begin
            w_out_idx_n = r_out_idx + 16'd1;
            w_state_n   = w_sys_nxt ? EMIT : ENCODE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_lfsr      <= 32'd1;
      r_tag       <= '0;
      r_j         <= '0;
      r_wr        <= '0;
      r_fidx      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_lfsr      <= w_lfsr_n;
      r_tag       <= w_tag_n;
      r_j         <= w_j_n;
      r_wr        <= w_wr_n;
      r_fidx      <= w_fidx_n;
      r_acc       <= w_acc_n;
      r_out_data  <= w_out_data_n;
      r_out_tag   <= w_out_tag_n;
      r_out_idx   <= w_out_idx_n;
      r_out_valid <= w_out_valid_n;
      r_done      <= w_done_n;
      r_in_ready  <= (w_state_n == LOAD);
      r_busy      <= (w_state_n != IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fountain_lt_encoder.sv
// Randomised self-checking bench for fountain_lt_encoder (K=4, W=8) against a loop-based LT model.
module tb_fountain_lt_encoder;

  localparam int unsigned W = 8;
  localparam int unsigned K = 4;
  localparam int unsigned NUM_OUT = 48;
  localparam logic [31:0] TB_POLY = 32'h80200003;
`ifdef FOUNTAIN_SYSTEMATIC_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = K + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  seed = '0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [31:0]  out_tag;
  logic [15:0]  out_idx;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] src [K];
  logic [W-1:0] exp_data [NUM_OUT];
  logic [31:0]  exp_tag [NUM_OUT];
  logic [W-1:0] got_data [NUM_OUT];
  logic [31:0]  got_tag [NUM_OUT];

  fountain_lt_encoder #(.W(W), .K(K), .NUM_OUT(NUM_OUT), .POLY(TB_POLY)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_tag(out_tag), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each output symbol built from the LT rules with plain loops.
  task automatic build_expected(input logic [31:0] sd);
    logic [31:0]  l;
    logic [W-1:0] acc;
    l = (sd == 32'd0) ? 32'd1 : sd;
    for (int n = 0; n < NUM_OUT; n++) begin
`ifdef FOUNTAIN_SYSTEMATIC_EN
      if (n < K) begin
        exp_data[n] = src[n];
        exp_tag[n]  = 32'd0;
        continue;
      end
`endif
      exp_tag[n] = l;
      acc = '0;
      for (int j = 0; j < K; j++) begin
        if (l[0] || (j == (n % K))) acc = acc ^ src[j];
        l = (l >> 1) ^ (l[0] ? TB_POLY : 32'd0);
      end
      exp_data[n] = acc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_and_load(input logic [31:0] sd, input bit gaps);
    int n, cyc;
    bit hs;
    seed = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    cyc = 0;
    while (n < K && cyc < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = src[n];
      hs = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) n++;
    end
    in_valid = 1'b0;
    if (n < K) check("load_timeout", 64'(n), 64'(K));
  endtask

  // mode 0: ready always high; 1: random ready; 2: 10-cycle stall on symbol 2.
  task automatic collect(input int mode);
    int got, cyc, tail, done_cnt, stall_used;
    bit first_seen, pend;
    logic [W-1:0] held_d;
    logic [31:0]  held_t;
    got = 0; cyc = 0; tail = 0; done_cnt = 0; stall_used = 0;
    first_seen = 0; pend = 0; held_d = '0; held_t = '0;
    while (tail < 3 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (got >= NUM_OUT) tail++;
      if (done) done_cnt++;
      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_latency", 64'(cyc), 64'(FIRST_LAT));
        end
        if (pend) begin
          check("stall_data", 64'(out_data), 64'(held_d));
          check("stall_tag", 64'(out_tag), 64'(held_t));
        end
      end
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (got == 2 && out_valid && stall_used < 10) begin
            out_ready = 1'b0;
            stall_used++;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready && got < NUM_OUT) begin
        check("sym_data", 64'(out_data), 64'(exp_data[got]));
        check("sym_tag", 64'(out_tag), 64'(exp_tag[got]));
        check("sym_idx", 64'(out_idx), 64'(got));
        got_data[got] = out_data;
        got_tag[got]  = out_tag;
        got++;
        pend = 0;
      end else if (out_valid) begin
        pend = 1;
        held_d = out_data;
        held_t = out_tag;
      end
    end
    out_ready = 1'b0;
    if (got < NUM_OUT) check("collect_timeout", 64'(got), 64'(NUM_OUT));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_after_block", 64'(busy), 64'd0);
    check("valid_after_block", 64'(out_valid), 64'd0);
    if (mode == 2) check("stall_cycles", 64'(stall_used), 64'd10);
  endtask

  task automatic check_directed();
`ifdef FOUNTAIN_SYSTEMATIC_EN
    for (int i = 0; i < K; i++) begin
      check("sys_data", 64'(got_data[i]), 64'(src[i]));
      check("sys_tag", 64'(got_tag[i]), 64'd0);
    end
    check("repair0_data", 64'(got_data[K]), 64'h0B);
    check("repair0_tag", 64'(got_tag[K]), 64'h00000001);
`else
    check("sym0_data", 64'(got_data[0]), 64'h0B);
    check("sym0_tag", 64'(got_tag[0]), 64'h00000001);
    check("sym1_tag", 64'(got_tag[1]), 64'hB02C0003);
`endif
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd0);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_out_data"}, 64'(out_data), 64'd0);
    check({pfx, "_out_tag"}, 64'(out_tag), 64'd0);
    check({pfx, "_out_idx"}, 64'(out_idx), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    do_reset();
    check_zero_outputs("reset");

    // Directed block: seed 1, sources 01 02 04 08.
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h04; src[3] = 8'h08;
    build_expected(32'd1);
    start_and_load(32'd1, 1'b0);
    collect(0);
    check_directed();

    // Seed 0 behaves as seed 1.
    start_and_load(32'd0, 1'b0);
    collect(0);
    check_directed();

    // Ten-cycle stall must leave the sequence unchanged.
    start_and_load(32'd1, 1'b0);
    collect(2);
    check_directed();

    // Reset asserted mid-block clears outputs asynchronously.
    start_and_load(32'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_and_load(32'd1, 1'b0);
    collect(0);
    check_directed();

    // Random seeds, data, input gaps and back-pressure.
    for (int b = 0; b < 5; b++) begin
      logic [31:0] sd;
      for (int i = 0; i < K; i++) src[i] = W'($urandom);
      sd = (b == 0) ? 32'd0 : $urandom;
      build_expected(sd);
      start_and_load(sd, 1'b1);
      collect(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
